// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline stage.
//   DATA_W / REG_ADDR_W : payload field widths
//   CTRL_*              : bit positions inside the 5-bit control bundle
//   state_t             : skid-buffer occupancy states
//   payload_t           : one captured EX instruction (without its zero flag)
package ex_mem_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 5;

  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_BRANCH   = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     write_data;
    logic [DATA_W-1:0]     branch_target;
    logic [REG_ADDR_W-1:0] write_reg;
  } payload_t;

  function automatic logic is_zero(input logic [DATA_W-1:0] value);
    return ~|value;
  endfunction

endpackage

// File: rtl/ex_mem_entry.sv
// One payload slot of the EX/MEM skid buffer.
//   Clk, Rst : clock, async active-low reset (clears the slot to zero)
//   load     : capture payload on the rising edge
//   payload  : incoming instruction fields
//   held     : stored fields
//   zero     : ALU result of the stored payload was zero (computed at capture)
module ex_mem_entry
  import ex_mem_pkg::*;
(
  input  logic     Clk,
  input  logic     Rst,
  input  logic     load,
  input  payload_t payload,
  output payload_t held,
  output logic     zero
);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      held <= '0;
      zero <= 1'b0;
    end else if (load) begin
      held <= payload;
      zero <= is_zero(payload.alu_result);
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: two-entry skid buffer between the ALU and the MEM
// stage, with registered zero flag, beq resolution and a retire counter.
//   Clk, Rst                      : clock, async active-low reset
//   InValid/InReady               : EX-side handshake (InReady is registered)
//   ALUResult, WriteData, WriteReg, BranchTarget, CtrlIn : instruction payload
//   Flush                         : synchronous kill of all held entries
//   OutValid/OutReady             : MEM-side handshake
//   *Out, ZeroOut, BranchTaken    : head entry view (zero while invalid)
//   RetiredCount                  : number of entries handed to MEM
//
// state | meaning
// EMPTY | no valid entry
// ONE   | head valid, skid empty
// FULL  | head and skid valid, input stalled
module ex_mem_stage
  import ex_mem_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DATA_W-1:0]     ALUResult,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic [REG_ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0]     BranchTarget,
  input  logic [CTRL_W-1:0]     CtrlIn,
  input  logic                  Flush,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_W-1:0]     ALUResultOut,
  output logic [DATA_W-1:0]     WriteDataOut,
  output logic [DATA_W-1:0]     BranchTargetOut,
  output logic [REG_ADDR_W-1:0] WriteRegOut,
  output logic [CTRL_W-1:0]     CtrlOut,
  output logic                  ZeroOut,
  output logic                  BranchTaken,
  output logic [31:0]           RetiredCount
);

  state_t   state, state_next;
  logic     in_xfer, out_xfer;
  logic     head_load, skid_load;
  payload_t in_payload, head_src, head_held, skid_held;
  logic     head_zero, skid_zero;
  logic     head_zero_unused;
  logic [31:0] retired_count;

  assign in_payload = '{ctrl:          CtrlIn,
                        alu_result:    ALUResult,
                        write_data:    WriteData,
                        branch_target: BranchTarget,
                        write_reg:     WriteReg};

  // Both handshake flags come straight from the state register, so MEM
  // backpressure never reaches EX combinationally.
  assign OutValid = (state != EMPTY);
  assign InReady  = (state != FULL);
  assign in_xfer  = InValid & InReady;
  assign out_xfer = OutValid & OutReady;

  // The head refills from the skid when draining out of FULL, otherwise
  // from the input.
  assign head_src = (state == FULL) ? skid_held : in_payload;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state         <= EMPTY;
      retired_count <= '0;
    end else begin
      state <= state_next;
      if (out_xfer && !Flush) retired_count <= retired_count + 32'd1;
    end
  end

  always_comb begin
    state_next = state;
    head_load  = 1'b0;
    skid_load  = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_next = ONE;
          head_load  = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          head_load = 1'b1;
        end else if (in_xfer) begin
          state_next = FULL;
          skid_load  = 1'b1;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_next = ONE;
          head_load  = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush overrides everything decided above, including the capture.
    if (Flush) begin
      state_next = EMPTY;
      head_load  = 1'b0;
      skid_load  = 1'b0;
    end
  end

  ex_mem_entry u_head (
    .Clk     (Clk),
    .Rst     (Rst),
    .load    (head_load),
    .payload (head_src),
    .held    (head_held),
    .zero    (head_zero)
  );

  ex_mem_entry u_skid (
    .Clk     (Clk),
    .Rst     (Rst),
    .load    (skid_load),
    .payload (in_payload),
    .held    (skid_held),
    .zero    (skid_zero)
  );

  // The skid's zero flag is implied again when its payload moves to the head.
  assign head_zero_unused = skid_zero;

  // Head view is masked while invalid so stale data never leaks to MEM.
  assign ALUResultOut    = OutValid ? head_held.alu_result    : '0;
  assign WriteDataOut    = OutValid ? head_held.write_data    : '0;
  assign BranchTargetOut = OutValid ? head_held.branch_target : '0;
  assign WriteRegOut     = OutValid ? head_held.write_reg     : '0;
  assign CtrlOut         = OutValid ? head_held.ctrl          : '0;
  assign ZeroOut         = OutValid & head_zero;
  assign BranchTaken     = ZeroOut & CtrlOut[CTRL_BRANCH];
  assign RetiredCount    = retired_count;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  logic        Clk, Rst;
  logic        InValid, InReady, Flush, OutValid, OutReady;
  logic [31:0] ALUResult, WriteData, BranchTarget;
  logic [4:0]  WriteReg, CtrlIn;
  logic [31:0] ALUResultOut, WriteDataOut, BranchTargetOut;
  logic [4:0]  WriteRegOut, CtrlOut;
  logic        ZeroOut, BranchTaken;
  logic [31:0] RetiredCount;

  ex_mem_stage dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .ALUResult(ALUResult), .WriteData(WriteData), .WriteReg(WriteReg),
    .BranchTarget(BranchTarget), .CtrlIn(CtrlIn), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .ALUResultOut(ALUResultOut),
    .WriteDataOut(WriteDataOut), .BranchTargetOut(BranchTargetOut),
    .WriteRegOut(WriteRegOut), .CtrlOut(CtrlOut), .ZeroOut(ZeroOut),
    .BranchTaken(BranchTaken), .RetiredCount(RetiredCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] alu, wd, bt;
    logic [4:0]  wr, ctrl;
  } item_t;

  item_t       mq[$];
  logic [31:0] mcount;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a FIFO of at most two instructions; ready whenever not full.
  task automatic model_edge();
    item_t it;
    bit    in_x, out_x;
    in_x  = InValid && (mq.size() < 2);
    out_x = OutReady && (mq.size() > 0);
    if (!Rst) begin
      mq.delete();
      mcount = 0;
    end else if (Flush) begin
      mq.delete();
    end else begin
      if (out_x) begin
        void'(mq.pop_front());
        mcount = mcount + 32'd1;
      end
      if (in_x) begin
        it.alu = ALUResult; it.wd = WriteData; it.bt = BranchTarget;
        it.wr = WriteReg; it.ctrl = CtrlIn;
        mq.push_back(it);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  task automatic check_all(input string tag);
    item_t h;
    bit    v, z;
    h = '{alu: 0, wd: 0, bt: 0, wr: 0, ctrl: 0};
    v = (mq.size() > 0);
    if (v) h = mq[0];
    z = v && (h.alu == 0);
    check({tag, ".valid"},  OutValid, v);
    check({tag, ".ready"},  InReady, mq.size() < 2);
    check({tag, ".alu"},    ALUResultOut, h.alu);
    check({tag, ".wd"},     WriteDataOut, h.wd);
    check({tag, ".bt"},     BranchTargetOut, h.bt);
    check({tag, ".wr"},     WriteRegOut, h.wr);
    check({tag, ".ctrl"},   CtrlOut, h.ctrl);
    check({tag, ".zero"},   ZeroOut, z);
    check({tag, ".taken"},  BranchTaken, z && h.ctrl[0]);
    check({tag, ".count"},  RetiredCount, mcount);
  endtask

  task automatic drive(input bit v, input logic [31:0] alu, input logic [4:0] ctrl,
                       input logic [31:0] bt);
    InValid = v; ALUResult = alu; CtrlIn = ctrl; BranchTarget = bt;
    WriteData = alu ^ 32'hA5A5_0000; WriteReg = alu[4:0] ^ 5'd7;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] base;
    mcount = 0;
    Rst = 1'b0; Flush = 1'b0; OutReady = 1'b0;
    drive(0, 0, 0, 0);
    @(negedge Clk); @(negedge Clk);
    check_all("reset");
    Rst = 1'b1;

    // single op
    drive(1, 32'h5, 5'b10000, 32'h0); OutReady = 1'b1;
    tick(); drive(0, 0, 0, 0);
    check_all("single");
    check("single.alu_const", ALUResultOut, 32'h5);
    check("single.taken_const", BranchTaken, 1'b0);
    tick();
    check("single.retired", RetiredCount, 32'd1);

    // branch resolution
    drive(1, 32'h0, 5'b00001, 32'h0040_0020);
    tick(); drive(0, 0, 0, 0);
    check_all("beq_taken");
    check("beq_taken.const", BranchTaken, 1'b1);
    check("beq_target.const", BranchTargetOut, 32'h0040_0020);
    drive(1, 32'hFFFF_FFFF, 5'b00001, 32'h0040_0020);
    tick(); drive(0, 0, 0, 0);
    check_all("beq_not");
    check("beq_not.const", BranchTaken, 1'b0);
    tick();

    // backpressure
    OutReady = 1'b0;
    drive(1, 32'h11, 5'b11000, 32'h0); tick(); check_all("bp_a");
    drive(1, 32'h22, 5'b11000, 32'h0); tick(); check_all("bp_b");
    check("bp.ready_low", InReady, 1'b0);
    check("bp.head_a", ALUResultOut, 32'h11);
    drive(1, 32'h33, 5'b11000, 32'h0); tick(); check_all("bp_hold");
    drive(0, 0, 0, 0); OutReady = 1'b1;
    tick(); check_all("bp_drain1");
    check("bp.head_b", ALUResultOut, 32'h22);
    tick(); check_all("bp_drain2");
    check("bp.empty_ready", InReady, 1'b1);

    // streaming
    base = mcount;
    for (int i = 0; i < 100; i++) begin
      drive(1, i, 5'b10000, 32'h0); tick();
      check_all("stream");
      check("stream.head", ALUResultOut, i);
    end
    drive(0, 0, 0, 0); tick(); check_all("stream_end");
    check("stream.retired", RetiredCount, base + 32'd100);

    // flush while FULL with a same-cycle input
    OutReady = 1'b0;
    drive(1, 32'h44, 5'b0, 32'h0); tick();
    drive(1, 32'h55, 5'b0, 32'h0); tick();
    base = mcount;
    drive(1, 32'h66, 5'b0, 32'h0); Flush = 1'b1; tick();
    Flush = 1'b0; drive(0, 0, 0, 0);
    check_all("flush");
    check("flush.valid", OutValid, 1'b0);
    check("flush.count", RetiredCount, base);
    OutReady = 1'b1; tick(); check_all("flush_after");

    // async reset while FULL
    OutReady = 1'b0;
    drive(1, 32'h77, 5'b0, 32'h0); tick();
    drive(1, 32'h88, 5'b0, 32'h0); tick();
    drive(0, 0, 0, 0);
    #2 Rst = 1'b0;
    #1 check("areset.valid", OutValid, 1'b0);
    check("areset.count", RetiredCount, 32'd0);
    mq.delete(); mcount = 0;
    tick(); Rst = 1'b1;
    check_all("areset_after");
    tick(); check_all("areset_idle");

    // counter wrap
    force dut.retired_count = 32'hFFFF_FFFF;
    #1 release dut.retired_count;
    mcount = 32'hFFFF_FFFF;
    OutReady = 1'b1;
    drive(1, 32'h99, 5'b0, 32'h0); tick();
    drive(0, 0, 0, 0); tick();
    check_all("wrap");
    check("wrap.zero", RetiredCount, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3, 0) != 0,
            ($urandom_range(3, 0) == 0) ? 32'h0 : $urandom(),
            5'($urandom()), $urandom());
      OutReady = ($urandom_range(2, 0) != 0);
      Flush    = ($urandom_range(24, 0) == 0);
      tick();
      check_all("rand");
    end
    Flush = 1'b0; drive(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
